// File: rtl/csdf_switch_ms.sv
// ---------------------------------------------------------------------------
// csdf_switch_ms : cyclo-static SWITCH actor (dual of PICK).
//
// Tokens pushed by the upstream actor are buffered in a small FIFO and
// forwarded, strictly in order, to one of PORTS output push ports. The
// destination follows a fixed schedule of NUM_OP phases; each phase forwards
// RATE tokens to port (phase mod PORTS), after which the schedule advances
// and wraps.
//
// Ports
//   ck        : clock, rising edge
//   rst       : synchronous reset, active-low
//   in_wr     : upstream push strobe
//   in_data   : upstream push data
//   in_full   : FIFO full, back to upstream (from registered count)
//   out_wr    : per-port one-cycle write pulse
//   out_data  : per-port data, port k at [k*WIDTH +: WIDTH], held between fires
//   out_full  : per-port full from downstream FIFOs
//   phase     : current schedule phase, for observation
// ---------------------------------------------------------------------------
module csdf_switch_ms #(
    parameter  int WIDTH  = 8,
    parameter  int PORTS  = 2,
    parameter  int NUM_OP = 4,
    parameter  int RATE   = 2,
    parameter  int DEPTH  = 4,
    localparam int PW     = (NUM_OP > 1) ? $clog2(NUM_OP) : 1
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic                   in_wr,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_full,
    output logic [PORTS-1:0]       out_wr,
    output logic [PORTS*WIDTH-1:0] out_data,
    input  logic [PORTS-1:0]       out_full,
    output logic [PW-1:0]          phase
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int DW = $clog2(PORTS);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [AW-1:0]          r_wp;
    logic [AW-1:0]          r_rp;
    logic [CW-1:0]          r_cnt;
    logic [PW-1:0]          r_phase;
    logic [TW-1:0]          r_tok;
    logic [PORTS-1:0]       r_out_wr;
    logic [PORTS*WIDTH-1:0] r_out_data;

    logic                   w_full;
    logic                   w_push;
    logic                   w_fire;
    logic [DW-1:0]          w_dst;
    logic [WIDTH-1:0]       w_head;
    logic [PORTS-1:0]       w_wr_next;

    // ---------------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------------
    always_comb begin
        w_full = (r_cnt == CW'(DEPTH));
        // Full is judged on the registered count, so a same-cycle pop never
        // opens room for a push.
        w_push = in_wr && !w_full;
        w_dst  = DW'(int'(r_phase) % PORTS);
        w_head = r_mem[r_rp];
        // Head-of-line blocking: only the current destination's full matters.
        w_fire = (r_cnt != '0) && !out_full[w_dst];
        w_wr_next = '0;
        if (w_fire) begin
            w_wr_next[w_dst] = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO storage (contents need no reset; count/pointers gate validity)
    // ---------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO pointers, count, schedule state and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_tok      <= '0;
            r_out_wr   <= '0;
            r_out_data <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_fire) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_fire})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (w_fire) begin
                if (r_tok == TW'(RATE - 1)) begin
                    r_tok   <= '0;
                    r_phase <= (r_phase == PW'(NUM_OP - 1)) ? '0 : r_phase + PW'(1);
                end else begin
                    r_tok <= r_tok + TW'(1);
                end
            end

            r_out_wr <= w_wr_next;
            for (int unsigned k = 0; k < PORTS; k++) begin
                if (w_wr_next[k]) begin
                    r_out_data[k*WIDTH +: WIDTH] <= w_head;
                end
            end
        end
    end

    assign in_full  = w_full;
    assign out_wr   = r_out_wr;
    assign out_data = r_out_data;
    assign phase    = r_phase;

endmodule

// File: tb/tb_csdf_switch_ms.sv
// ---------------------------------------------------------------------------
// tb_csdf_switch_ms : directed self-checking bench for csdf_switch_ms with
// default parameters (WIDTH=8, PORTS=2, NUM_OP=4, RATE=2, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_csdf_switch_ms;

    logic        ck = 1'b0;
    logic        rst;
    logic        in_wr;
    logic [7:0]  in_data;
    logic        in_full;
    logic [1:0]  out_wr;
    logic [15:0] out_data;
    logic [1:0]  out_full;
    logic [1:0]  phase;

    int total = 0;
    int bad   = 0;

    csdf_switch_ms #(
        .WIDTH  (8),
        .PORTS  (2),
        .NUM_OP (4),
        .RATE   (2),
        .DEPTH  (4)
    ) dut (
        .ck       (ck),
        .rst      (rst),
        .in_wr    (in_wr),
        .in_data  (in_data),
        .in_full  (in_full),
        .out_wr   (out_wr),
        .out_data (out_data),
        .out_full (out_full),
        .phase    (phase)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_wr    = 1'b0;
        in_data  = 8'h00;
        out_full = 2'b00;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int k;
        int d;

        // ---------------- reset with in_wr held high ----------------
        rst      = 1'b0;
        in_wr    = 1'b1;
        in_data  = 8'h77;
        out_full = 2'b00;
        tick();
        tick();
        chk("rst_out_wr",   32'(out_wr),   32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_in_full",  32'(in_full),  32'h0);
        chk("rst_phase",    32'(phase),    32'h0);
        rst   = 1'b1;
        in_wr = 1'b0;
        tick();
        tick();
        chk("rst_nothing_stored_wr", 32'(out_wr), 32'h0);
        chk("rst_nothing_stored_cnt", 32'(dut.r_cnt), 32'h0);

        // ---------------- schedule routing: 1..8 back-to-back ----------------
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) begin
                in_wr   = 1'b1;
                in_data = 8'(i);
            end else begin
                in_wr = 1'b0;
            end
            tick();
            if (i >= 2) begin
                k = i - 1;                     // token that just fired
                d = ((k - 1) / 2) % 2;         // expected destination port
                chk($sformatf("sched_wr_t%0d", k),   32'(out_wr), 32'(2'b01 << d));
                chk($sformatf("sched_data_t%0d", k), 32'(out_data[d*8 +: 8]), 32'(k));
                chk($sformatf("sched_phase_t%0d", k), 32'(phase), 32'((k / 2) % 4));
            end
        end
        tick();
        chk("sched_idle_wr", 32'(out_wr), 32'h0);

        // ---------------- latency: single push ----------------
        do_reset();
        in_wr   = 1'b1;
        in_data = 8'hA5;
        tick();                                 // edge 0: push
        in_wr = 1'b0;
        chk("lat_edge0_wr", 32'(out_wr), 32'h0);
        tick();                                 // edge 1: fire
        chk("lat_edge1_wr",    32'(out_wr),         32'h1);
        chk("lat_edge1_data",  32'(out_data[7:0]),  32'hA5);
        chk("lat_edge1_phase", 32'(phase),          32'h0);
        chk("lat_edge1_tok",   32'(dut.r_tok),      32'h1);
        tick();
        chk("lat_pulse_end", 32'(out_wr), 32'h0);

        // ---------------- backpressure and full ----------------
        do_reset();
        out_full = 2'b10;
        for (int i = 0; i < 6; i++) begin
            in_wr   = 1'b1;
            in_data = 8'(8'h10 + i);
            tick();
            if (i == 1) begin
                chk("bp_t10_wr",   32'(out_wr),        32'h1);
                chk("bp_t10_data", 32'(out_data[7:0]), 32'h10);
            end else if (i == 2) begin
                chk("bp_t11_wr",    32'(out_wr),        32'h1);
                chk("bp_t11_data",  32'(out_data[7:0]), 32'h11);
                chk("bp_t11_phase", 32'(phase),         32'h1);
            end else if (i >= 3) begin
                chk($sformatf("bp_stall_wr%0d", i), 32'(out_wr), 32'h0);
            end
        end
        chk("bp_in_full", 32'(in_full), 32'h1);
        in_data = 8'h16;                         // dropped
        tick();
        chk("bp_drop_full", 32'(in_full),   32'h1);
        chk("bp_drop_wr",   32'(out_wr),    32'h0);
        chk("bp_drop_cnt",  32'(dut.r_cnt), 32'h4);
        in_wr    = 1'b0;
        out_full = 2'b00;
        tick();
        chk("bp_t12_wr",   32'(out_wr),         32'h2);
        chk("bp_t12_data", 32'(out_data[15:8]), 32'h12);
        chk("bp_t12_full", 32'(in_full),        32'h0);
        tick();
        chk("bp_t13_wr",   32'(out_wr),         32'h2);
        chk("bp_t13_data", 32'(out_data[15:8]), 32'h13);
        tick();
        chk("bp_t14_wr",   32'(out_wr),        32'h1);
        chk("bp_t14_data", 32'(out_data[7:0]), 32'h14);
        tick();
        chk("bp_t15_wr",    32'(out_wr),        32'h1);
        chk("bp_t15_data",  32'(out_data[7:0]), 32'h15);
        chk("bp_t15_phase", 32'(phase),         32'h3);
        tick();
        chk("bp_no_t16_wr", 32'(out_wr), 32'h0);

        // ---------------- full plus pop in the same cycle ----------------
        do_reset();
        out_full = 2'b11;
        for (int i = 0; i < 4; i++) begin
            in_wr   = 1'b1;
            in_data = 8'(8'h20 + i);
            tick();
        end
        chk("fp_full_before", 32'(in_full), 32'h1);
        out_full = 2'b00;
        in_data  = 8'h24;                        // refused: full on registered count
        tick();
        in_wr = 1'b0;
        chk("fp_pop_wr",   32'(out_wr),        32'h1);
        chk("fp_pop_data", 32'(out_data[7:0]), 32'h20);
        chk("fp_cnt3",     32'(dut.r_cnt),     32'h3);
        chk("fp_full_off", 32'(in_full),       32'h0);
        tick();
        chk("fp_t21_data", 32'(out_data[7:0]), 32'h21);
        tick();
        chk("fp_t22_wr",   32'(out_wr),         32'h2);
        chk("fp_t22_data", 32'(out_data[15:8]), 32'h22);
        tick();
        chk("fp_t23_data", 32'(out_data[15:8]), 32'h23);
        tick();
        chk("fp_no_t24_wr", 32'(out_wr), 32'h0);

        // ---------------- mid-operation reset ----------------
        do_reset();
        out_full = 2'b10;
        for (int i = 0; i < 4; i++) begin
            in_wr   = 1'b1;
            in_data = 8'(8'h30 + i);
            tick();
        end
        out_full = 2'b00;
        in_data  = 8'h34;
        tick();                                  // 0x32 routed to port1, 0x33/0x34 buffered
        in_wr = 1'b0;
        chk("mr_pre_phase", 32'(phase),         32'h1);
        chk("mr_pre_tok",   32'(dut.r_tok),     32'h1);
        chk("mr_pre_cnt",   32'(dut.r_cnt),     32'h2);
        chk("mr_pre_data",  32'(out_data[15:8]), 32'h32);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_rst_wr",    32'(out_wr),     32'h0);
        chk("mr_rst_phase", 32'(phase),      32'h0);
        chk("mr_rst_tok",   32'(dut.r_tok),  32'h0);
        chk("mr_rst_cnt",   32'(dut.r_cnt),  32'h0);
        chk("mr_rst_data",  32'(out_data),   32'h0);
        in_wr   = 1'b1;
        in_data = 8'h40;
        tick();
        in_wr = 1'b0;
        tick();
        chk("mr_next_wr",   32'(out_wr),        32'h1);
        chk("mr_next_data", 32'(out_data[7:0]), 32'h40);
        tick();
        chk("mr_stale_gone", 32'(out_wr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csdf_switch_ms.md
Name: csdf_switch_ms

Overview:
- Cyclo-static SWITCH actor: dual of the PICK actor, placed directly downstream of the PICK actor's out0 push port.
- Buffers incoming tokens in an internal FIFO and routes them to PORTS output push ports following a fixed phase schedule.
- Each phase forwards RATE tokens to one destination. The schedule is NUM_OP phases long, then wraps.

Parameters:
- WIDTH, 8, token data width in bits.
- PORTS, 2, number of output ports (>=2).
- NUM_OP, 4, phases per schedule cycle (>=1).
- RATE, 2, tokens forwarded per phase (>=1).
- DEPTH, 4, input FIFO entries (power of 2, >=2).

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- in_wr  input  1  push strobe from upstream actor (out0_wr).
- in_data  input  WIDTH  push data (out0_data).
- in_full  output  1  FIFO full, back to upstream (out0_full).
- out_wr  output  PORTS  per-port write pulse.
- out_data  output  PORTS*WIDTH  per-port data; port k occupies bits [k*WIDTH +: WIDTH].
- out_full  input  PORTS  per-port full from downstream FIFOs.
- phase  output  clog2(NUM_OP), min 1  current phase index, for observation.

Behaviour:
- Reset (rst==0 at a rising edge):
  - FIFO count, read and write pointers cleared; contents discarded.
  - phase=0, token counter tok=0.
  - out_wr=0, out_data=0, in_full=0.
  - Reset mid-operation discards buffered tokens and any pending routing; no out_wr the cycle after reset.
- Input FIFO:
  - Push accepted when in_wr==1 and in_full==0.
  - in_full is driven from the registered count (count==DEPTH), never from a same-cycle pop.
  - in_wr while in_full==1: token dropped, no state change.
- Destination: dst = phase mod PORTS.
- Fire condition (combinational): count!=0 and out_full[dst]==0.
- On a fire edge:
  - Pop the FIFO head.
  - Register out_wr[dst]=1 and out_data[dst]=head.
  - All other out_wr bits 0.
- out_wr is a one-cycle pulse per token. out_data[k] holds its last value until port k fires again.
- Strict in-order delivery with head-of-line blocking:
  - A full destination stalls everything; out_full of non-destination ports is ignored.
  - No skipping or reordering.
- Schedule advance, on each fire only:
  - If tok==RATE-1: tok=0, and phase = (phase==NUM_OP-1) ? 0 : phase+1.
  - Else tok=tok+1.
  - phase and tok never change without a fire.
- Simultaneous push and pop: both take effect; count unchanged. Push while full is refused even if a pop occurs in the same cycle.
- Latency: token pushed at edge t is at the FIFO head after t. Earliest fire is edge t+1, so out_wr is high in the cycle after edge t+1 (2-edge latency).
- Throughput: one token per clock sustained while not stalled.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally; the count distinguishes full from empty.

Test Plan:
- Reset: hold rst=0 for 2 edges with in_wr=1 -> out_wr=0, out_data=0, in_full=0, phase=0; nothing stored after release.
- Schedule routing (defaults, out_full=0): push 1..8 back-to-back -> port0 receives 1,2; port1 receives 3,4; port0 receives 5,6; port1 receives 7,8. phase sequence 0,1,2,3 then back to 0. One out_wr bit per cycle.
- Latency: single push of 0xA5 at edge 0 -> out_wr[0]=1 with out_data[0]=0xA5 after edge 1 only; phase stays 0, tok=1.
- Backpressure and full:
  - Setup: out_full[1]=1 while phase=1; push 0x10..0x15.
  - Expected: tokens 0x10,0x11 go to port0 and are not buffered. Port1 stalls with 0x12..0x15 buffered, so in_full=1 and no out_wr bits asserted.
  - A 7th push of 0x16 is dropped.
  - Release out_full[1]: port1 gets 0x12,0x13, then port0 gets 0x14,0x15; 0x16 never appears.
- Full plus pop: FIFO full with fire enabled and in_wr=1 in the same cycle -> push refused, count goes 4->3, in_full deasserts next cycle.
- Mid-operation reset: after 3 tokens routed (phase=1, tok=1), assert rst with 2 buffered -> phase=0, tok=0, FIFO empty. Next pushed token goes to port0.
